// File: rtl/uart_io_port.sv
// CPU-side UART port: RX deserializer feeding INPR/FGI and TX serializer fed by OUTR/FGO,
// with sticky overrun, framing and dropped-write error flags.
module uart_io_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       fgi_clr,
  input  logic [7:0] outr,
  input  logic       out_wr,
  output logic       fgo,
  input  logic       err_clr,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       tx_drop
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic [7:0]    rx_shift;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_idx;
  logic [7:0]    tx_shift;

  // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Clears are written first so that a load or error set later in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      inpr         <= '0;
      fgi          <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (fgi_clr) fgi <= 1'b0;
      if (err_clr) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
            rx_idx   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt   <= '0;
            rx_shift <= {rxs, rx_shift[7:1]};
            if (rx_idx == 4'd7) begin
              rx_idx   <= '0;
              rx_state <= RX_STOP;
            end else begin
              rx_idx <= rx_idx + 4'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt <= '0;
            if (!rxs) begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT_HIGH;
            end else begin
              rx_state <= RX_IDLE;
              if (!fgi || fgi_clr) begin
                inpr <= rx_shift;
                fgi  <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // uart_txd is registered; every bit boundary updates it on the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
      fgo      <= 1'b1;
      tx_drop  <= 1'b0;
    end else begin
      if (err_clr) tx_drop <= 1'b0;
      if (out_wr && !fgo) tx_drop <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          uart_txd <= 1'b1;
          if (out_wr && fgo) begin
            tx_shift <= outr;
            fgo      <= 1'b0;
            uart_txd <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == FULL_M1) begin
            tx_cnt   <= '0;
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == FULL_M1) begin
            tx_cnt <= '0;
            if (tx_idx == 4'd7) begin
              tx_idx   <= '0;
              uart_txd <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_idx   <= tx_idx + 4'd1;
              uart_txd <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == FULL_M1) begin
            tx_cnt   <= '0;
            fgo      <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_io_port.md
Name: uart_io_port

Overview:
- CPU-side UART I/O port for the ex3 accumulator machine. It is the computer end of the serial link driven by the UART device models.
- Receive path: deserializes uart_rxd into INPR and raises FGI. The CPU consumes the byte with INP.
- Transmit path: accepts OUTR on an OUT instruction, drops FGO and serializes the byte on uart_txd.
- Sits between the CPU datapath (INP/OUT/SKI/SKO flag logic) and the board UART pins.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be an even value of 2 or more.
- SYNC_STAGES, 2: flip-flop stages in the uart_rxd synchronizer; minimum 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial receive line; idles high.
- uart_txd  out  1  serial transmit line; idles high.
- inpr  out  8  last accepted received byte.
- fgi  out  1  input flag; 1 = inpr holds an unread byte.
- fgi_clr  in  1  one-cycle pulse on INP execution; clears fgi.
- outr  in  8  byte to transmit; sampled when out_wr is accepted.
- out_wr  in  1  one-cycle pulse on OUT execution.
- fgo  out  1  output flag; 1 = transmitter ready.
- err_clr  in  1  clears all sticky error bits.
- rx_overrun  out  1  sticky: a byte arrived while fgi=1.
- rx_frame_err  out  1  sticky: stop bit sampled as 0.
- tx_drop  out  1  sticky: out_wr received while fgo=0.

Behaviour:
- Reset (async, rst_n=0):
  - inpr=0, fgi=0, fgo=1, uart_txd=1, all error bits 0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts the frame immediately; a partial RX byte is discarded.
- RX synchronizer: uart_rxd passes through SYNC_STAGES flops, each reset to 1. All RX logic uses the synchronized value rxs.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: if rxs=0, go to START with the bit counter at 0.
  - START: after CLKS_PER_BIT/2 cycles, sample rxs.
    - rxs=1: glitch; return to IDLE with no flag change.
    - rxs=0: go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. 8 samples, LSB first, shifted into rx_shift. After the 8th sample go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs=1 and (fgi=0 or fgi_clr=1): inpr<=rx_shift, fgi<=1; go to IDLE.
    - rxs=1 and fgi=1 and fgi_clr=0: inpr unchanged, byte dropped, rx_overrun<=1; go to IDLE.
    - rxs=0: rx_frame_err<=1, no load; go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE when rxs=1.
  - Latency: inpr/fgi update at 9.5*CLKS_PER_BIT + SYNC_STAGES cycles (plus or minus 1) after the start-bit falling edge on the pin.
- fgi rules:
  - fgi_clr clears fgi on the next edge.
  - If fgi_clr and a load occur in the same cycle, the load wins: fgi=1 and inpr holds the new byte.
  - inpr is never cleared by fgi_clr.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: out_wr with fgo=1 latches outr into tx_shift and sets fgo<=0. uart_txd goes 0 on the next edge (START).
  - Each bit is held for exactly CLKS_PER_BIT cycles: start 0, then data bits 0..7 LSB first, then stop 1.
  - At the end of the stop bit: fgo<=1, return to IDLE. Busy time is exactly 10*CLKS_PER_BIT cycles from the out_wr edge to fgo=1.
  - A new out_wr accepted in the same cycle fgo rises begins the next frame back-to-back with no extra idle bit.
  - out_wr with fgo=0: ignored, the current frame is unaffected, tx_drop<=1.
  - outr is don't-care except in the cycle out_wr is accepted.
- Error bits:
  - Set conditions as above; cleared only by err_clr or reset.
  - When set and err_clr occur in the same cycle, the set wins.
- RX and TX are fully independent. A loopback of uart_txd to uart_rxd must work.
- Counter widths: ceil(log2(CLKS_PER_BIT)) bits for bit timing, 4 bits for bit index. No wrap beyond the terminal count.

Test Plan:
- CLKS_PER_BIT=4; drive frame 0x41 on uart_rxd -> inpr=0x41, fgi=1 about 38+2 cycles after the start edge; rx_frame_err=0.
- With fgi=1, send 0x42 with no fgi_clr -> rx_overrun=1, inpr stays 0x41. Then pulse fgi_clr, send 0x43 -> inpr=0x43, fgi=1. Pulse err_clr -> rx_overrun=0.
- Pulse fgi_clr in the exact cycle of a stop-bit load of 0x55 -> fgi=1, inpr=0x55, no overrun.
- Low glitch of 1 cycle on uart_rxd -> no state change. Frame 0xA5 with stop bit 0 -> rx_frame_err=1, fgi unchanged; next valid frame 0x5A received correctly after the line returns high.
- out_wr with outr=0x3C -> fgo=0 next cycle; uart_txd sequence 0,0,0,1,1,1,1,0,0,1 with each bit held 4 cycles; fgo=1 after 40 cycles. out_wr mid-frame -> tx_drop=1, waveform unchanged.
- Loopback txd->rxd, transmit 0x00, 0xFF, 0x0A back-to-back -> inpr/fgi deliver each byte in order (fgi_clr between bytes); no errors. Assert rst_n low mid-frame -> uart_txd=1, fgo=1, fgi=0 immediately.
